// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character LCD controller.
// Holds the memory-mapped word layout, the power-up command list and the wait-class helper.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_IDLE,
        ST_SETUP,
        ST_EN_HI,
        ST_HOLD,
        ST_WAIT
    } state_t;

    localparam int LCD_ON_BIT  = 31;
    localparam int LCD_STB_BIT = 10;
    localparam int LCD_RS_BIT  = 8;

    localparam int INIT_LEN = 6;
    localparam int INIT_IW  = $clog2(INIT_LEN);

    // Element 0 is sent first: 8-bit/2-line three times, display on, clear, entry mode.
    localparam logic [INIT_LEN-1:0][7:0] INIT_LIST = {
        8'h06, 8'h01, 8'h0C, 8'h38, 8'h38, 8'h38
    };

    localparam logic [7:0] OP_CLEAR    = 8'h01;
    localparam logic [7:0] OP_HOME     = 8'h02;
    localparam logic [7:0] OP_HOME_ALT = 8'h03;

    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == OP_CLEAR || data == OP_HOME || data == OP_HOME_ALT);
    endfunction

endpackage

// File: rtl/lcd_if.sv
// Bus between the memory-mapped LCD word and the character LCD pins.
// The master drives the CPU word; the slave (lcd_ctrl) drives the panel and status bits.
interface lcd_if;
    logic [31:0] io_lcd_i;
    logic [7:0]  lcd_data_o;
    logic        lcd_rs_o;
    logic        lcd_rw_o;
    logic        lcd_en_o;
    logic        lcd_on_o;
    logic        lcd_busy_o;
    logic        lcd_init_done_o;
    logic        lcd_ovf_o;

    modport master (
        output io_lcd_i,
        input  lcd_data_o, lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_on_o,
        input  lcd_busy_o, lcd_init_done_o, lcd_ovf_o
    );

    modport slave (
        input  io_lcd_i,
        output lcd_data_o, lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_on_o,
        output lcd_busy_o, lcd_init_done_o, lcd_ovf_o
    );
endinterface

// File: rtl/lcd_timer.sv
// Loadable down-counter shared by every timed FSM state.
// Holds at zero until the next load; the zero flag marks the last cycle of a state.
module lcd_timer #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 sequencer: power-up init list, then one buffered CPU byte per strobe toggle,
// with setup / enable / hold / execution-wait timing enforced per byte.
module lcd_ctrl #(
    parameter int T_PWRUP = 750_000,
    parameter int T_SETUP = 2,
    parameter int T_EN    = 12,
    parameter int T_HOLD  = 2,
    parameter int T_CMD   = 2_000,
    parameter int T_CLR   = 82_000
) (
    input logic  clk_i,
    input logic  rst_i,
    lcd_if.slave bus
);
    import lcd_pkg::*;

    localparam int T_MAX = (T_PWRUP > T_CLR) ? T_PWRUP : T_CLR;
    localparam int CW    = $clog2(T_MAX + 1);

    localparam logic [CW-1:0] LD_PWRUP = CW'(T_PWRUP - 1);
    localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] LD_EN    = CW'(T_EN - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] LD_CMD   = CW'(T_CMD - 1);
    localparam logic [CW-1:0] LD_CLR   = CW'(T_CLR - 1);
    localparam logic [INIT_IW-1:0] INIT_LAST = INIT_IW'(INIT_LEN - 1);

    state_t state, state_next;

    logic               timer_load;
    logic [CW-1:0]      timer_val;
    logic               timer_zero;

    logic               stb_q;
    logic               pend_valid;
    logic               pend_valid_next;
    logic               pend_rs;
    logic [7:0]         pend_data;
    logic               req;
    logic               take;

    logic [INIT_IW-1:0] init_idx;
    logic [INIT_IW-1:0] init_sel;
    logic               init_done;
    logic               load_init;
    logic               init_adv;
    logic               init_fin;

    logic [7:0]         data_q;
    logic               rs_q;
    logic               en_q;
    logic               on_q;
    logic               busy_q;
    logic               ovf_q;

    lcd_timer #(.W(CW)) u_timer (
        .clk      (clk_i),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (timer_zero)
    );

    assign req             = (bus.io_lcd_i[LCD_STB_BIT] != stb_q);
    assign pend_valid_next = req | (pend_valid & ~take);
    assign init_sel        = init_adv ? (init_idx + INIT_IW'(1)) : init_idx;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_PWRUP;
        end else begin
            state <= state_next;
        end
    end

    // The timer is reloaded on every state entry and also during reset, so PWRUP starts full.
    always_comb begin
        state_next = state;
        timer_load = 1'b0;
        timer_val  = '0;
        take       = 1'b0;
        load_init  = 1'b0;
        init_adv   = 1'b0;
        init_fin   = 1'b0;
        if (rst_i) begin
            timer_load = 1'b1;
            timer_val  = LD_PWRUP;
        end else begin
            case (state)
                ST_PWRUP: begin
                    if (timer_zero) begin
                        load_init  = 1'b1;
                        state_next = ST_SETUP;
                        timer_load = 1'b1;
                        timer_val  = LD_SETUP;
                    end
                end
                ST_IDLE: begin
                    if (pend_valid && init_done) begin
                        take       = 1'b1;
                        state_next = ST_SETUP;
                        timer_load = 1'b1;
                        timer_val  = LD_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (timer_zero) begin
                        state_next = ST_EN_HI;
                        timer_load = 1'b1;
                        timer_val  = LD_EN;
                    end
                end
                ST_EN_HI: begin
                    if (timer_zero) begin
                        state_next = ST_HOLD;
                        timer_load = 1'b1;
                        timer_val  = LD_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (timer_zero) begin
                        state_next = ST_WAIT;
                        timer_load = 1'b1;
                        timer_val  = is_long_cmd(rs_q, data_q) ? LD_CLR : LD_CMD;
                    end
                end
                ST_WAIT: begin
                    if (timer_zero) begin
                        if (init_done) begin
                            state_next = ST_IDLE;
                        end else if (init_idx == INIT_LAST) begin
                            init_fin   = 1'b1;
                            state_next = ST_IDLE;
                        end else begin
                            init_adv   = 1'b1;
                            load_init  = 1'b1;
                            state_next = ST_SETUP;
                            timer_load = 1'b1;
                            timer_val  = LD_SETUP;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stb_q      <= 1'b0;
            pend_valid <= 1'b0;
            pend_rs    <= 1'b0;
            pend_data  <= '0;
            init_idx   <= '0;
            init_done  <= 1'b0;
            data_q     <= '0;
            rs_q       <= 1'b0;
            en_q       <= 1'b0;
            on_q       <= 1'b0;
            busy_q     <= 1'b1;
            ovf_q      <= 1'b0;
        end else begin
            stb_q      <= bus.io_lcd_i[LCD_STB_BIT];
            pend_valid <= pend_valid_next;
            if (req) begin
                pend_rs   <= bus.io_lcd_i[LCD_RS_BIT];
                pend_data <= bus.io_lcd_i[7:0];
            end
            // A request landing on the same edge the buffer is drained is not an overwrite.
            if (req && pend_valid && !take) begin
                ovf_q <= 1'b1;
            end
            if (init_adv) begin
                init_idx <= init_sel;
            end
            if (init_fin) begin
                init_done <= 1'b1;
            end
            if (load_init) begin
                data_q <= INIT_LIST[init_sel];
                rs_q   <= 1'b0;
            end else if (take) begin
                data_q <= pend_data;
                rs_q   <= pend_rs;
            end
            en_q   <= (state_next == ST_EN_HI);
            on_q   <= bus.io_lcd_i[LCD_ON_BIT];
            busy_q <= (state_next != ST_IDLE) || pend_valid_next;
        end
    end

    logic unused_io;
    assign unused_io = ^{bus.io_lcd_i[30:11], bus.io_lcd_i[9]};

    assign bus.lcd_data_o      = data_q;
    assign bus.lcd_rs_o        = rs_q;
    assign bus.lcd_rw_o        = 1'b0;
    assign bus.lcd_en_o        = en_q;
    assign bus.lcd_on_o        = on_q;
    assign bus.lcd_busy_o      = busy_q;
    assign bus.lcd_init_done_o = init_done;
    assign bus.lcd_ovf_o       = ovf_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl: every EN pulse is matched against a queue of expected
// bytes and start cycles pushed when the matching stimulus (reset or strobe toggle) is driven.
module tb_lcd_ctrl;

    localparam int P_PWRUP = 20;
    localparam int P_SETUP = 2;
    localparam int P_EN    = 4;
    localparam int P_HOLD  = 2;
    localparam int P_CMD   = 10;
    localparam int P_CLR   = 30;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic clk;
    logic rst;
    lcd_if bus ();

    lcd_ctrl #(
        .T_PWRUP (P_PWRUP),
        .T_SETUP (P_SETUP),
        .T_EN    (P_EN),
        .T_HOLD  (P_HOLD),
        .T_CMD   (P_CMD),
        .T_CLR   (P_CLR)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    exp_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Expected timing model: each byte is setup + enable + hold + its execution wait.
    function automatic int xfer_len(input logic rs, input logic [7:0] data);
        return P_SETUP + P_EN + P_HOLD +
               ((!rs && (data == 8'h01 || data == 8'h02 || data == 8'h03)) ? P_CLR : P_CMD);
    endfunction

    int init_end;

    task automatic push_init(input int r);
        logic [7:0] init_bytes [6];
        int t;
        exp_t e;
        init_bytes = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
        t = r + P_PWRUP;
        for (int i = 0; i < 6; i++) begin
            e.rs   = 1'b0;
            e.data = init_bytes[i];
            e.cyc  = t + P_SETUP;
            sb.push_back(e);
            t += xfer_len(1'b0, init_bytes[i]);
        end
        init_end = t;
    endtask

    task automatic push_exp(input logic rs, input logic [7:0] data, input int c);
        exp_t e;
        e.rs   = rs;
        e.data = data;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic send_req(input logic rs, input logic [7:0] data, output int n);
        bus.io_lcd_i[10]  = ~bus.io_lcd_i[10];
        bus.io_lcd_i[8]   = rs;
        bus.io_lcd_i[7:0] = data;
        n = cyc + 1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.lcd_busy_o && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'b0, bus.lcd_busy_o}, 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_data"}, {24'b0, bus.lcd_data_o}, 32'd0);
        chk({tag, "_rs"}, {31'b0, bus.lcd_rs_o}, 32'd0);
        chk({tag, "_rw"}, {31'b0, bus.lcd_rw_o}, 32'd0);
        chk({tag, "_en"}, {31'b0, bus.lcd_en_o}, 32'd0);
        chk({tag, "_on"}, {31'b0, bus.lcd_on_o}, 32'd0);
        chk({tag, "_busy"}, {31'b0, bus.lcd_busy_o}, 32'd1);
        chk({tag, "_init_done"}, {31'b0, bus.lcd_init_done_o}, 32'd0);
        chk({tag, "_ovf"}, {31'b0, bus.lcd_ovf_o}, 32'd0);
    endtask

    // EN-pulse monitor: samples 1 time unit after each rising clock edge.
    initial begin
        logic in_pulse;
        int   en_len;
        exp_t e;
        in_pulse = 1'b0;
        en_len   = 0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rst) begin
                in_pulse = 1'b0;
                en_len   = 0;
            end else if (bus.lcd_en_o) begin
                if (!in_pulse) begin
                    in_pulse = 1'b1;
                    en_len   = 1;
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                    end else begin
                        e.rs   = 1'bx;
                        e.data = 8'hxx;
                        e.cyc  = -1;
                    end
                    chk("en_byte", {23'b0, bus.lcd_rs_o, bus.lcd_data_o}, {23'b0, e.rs, e.data});
                    chk("en_start_cycle", cyc, e.cyc);
                    chk("en_rw", {31'b0, bus.lcd_rw_o}, 32'd0);
                end else begin
                    en_len++;
                end
            end else if (in_pulse) begin
                in_pulse = 1'b0;
                chk("en_width", en_len, P_EN);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int n;
        int cnt;

        rst          = 1'b1;
        bus.io_lcd_i = '0;
        repeat (2) @(negedge clk);
        chk_reset_vals("por");
        r   = cyc;
        rst = 1'b0;
        push_init(r);

        wait_until(init_end - 1);
        chk("init_done_before", {31'b0, bus.lcd_init_done_o}, 32'd0);
        chk("busy_before_init_end", {31'b0, bus.lcd_busy_o}, 32'd1);
        @(negedge clk);
        chk("init_done_rise", {31'b0, bus.lcd_init_done_o}, 32'd1);
        chk("busy_fall_init", {31'b0, bus.lcd_busy_o}, 32'd0);

        bus.io_lcd_i[31] = 1'b1;
        @(negedge clk);
        chk("panel_on", {31'b0, bus.lcd_on_o}, 32'd1);

        // Data write RS=1 0x41 from IDLE.
        send_req(1'b1, 8'h41, n);
        push_exp(1'b1, 8'h41, n + 1 + P_SETUP);
        @(negedge clk);
        chk("busy_on_request", {31'b0, bus.lcd_busy_o}, 32'd1);
        @(negedge clk);
        chk("setup_data", {23'b0, bus.lcd_rs_o, bus.lcd_data_o}, {23'b0, 1'b1, 8'h41});
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (!bus.lcd_busy_o) break;
            cnt++;
            @(negedge clk);
        end
        chk("busy_cycles_from_setup", cnt, xfer_len(1'b1, 8'h41));
        chk("data_held_idle", {24'b0, bus.lcd_data_o}, 32'h41);

        // Clear command followed by a queued byte: long wait delays the second EN.
        send_req(1'b0, 8'h01, n);
        push_exp(1'b0, 8'h01, n + 1 + P_SETUP);
        repeat (3) @(negedge clk);
        send_req(1'b1, 8'h43, cnt);
        push_exp(1'b1, 8'h43, n + 1 + xfer_len(1'b0, 8'h01) + 1 + P_SETUP);
        wait_idle("idle_after_clear");
        chk("ovf_after_single_queue", {31'b0, bus.lcd_ovf_o}, 32'd0);

        // Two requests while one transfer runs: second overwrites the first.
        send_req(1'b1, 8'h50, n);
        push_exp(1'b1, 8'h50, n + 1 + P_SETUP);
        repeat (3) @(negedge clk);
        send_req(1'b1, 8'h41, cnt);
        @(negedge clk);
        chk("ovf_before_overwrite", {31'b0, bus.lcd_ovf_o}, 32'd0);
        send_req(1'b1, 8'h42, cnt);
        push_exp(1'b1, 8'h42, n + 1 + xfer_len(1'b1, 8'h50) + 1 + P_SETUP);
        @(negedge clk);
        chk("ovf_set", {31'b0, bus.lcd_ovf_o}, 32'd1);
        wait_idle("idle_after_overwrite");
        chk("ovf_sticky", {31'b0, bus.lcd_ovf_o}, 32'd1);

        // Toggle landing on the same edge the transfer completes.
        send_req(1'b1, 8'h60, n);
        push_exp(1'b1, 8'h60, n + 1 + P_SETUP);
        push_exp(1'b1, 8'h61, n + 1 + xfer_len(1'b1, 8'h60) + 1 + P_SETUP);
        wait_until(n + xfer_len(1'b1, 8'h60));
        send_req(1'b1, 8'h61, cnt);
        @(negedge clk);
        chk("busy_idle_with_pending", {31'b0, bus.lcd_busy_o}, 32'd1);
        chk("data_held_before_next", {24'b0, bus.lcd_data_o}, 32'h60);
        wait_idle("idle_after_simultaneous");

        // Reset while EN is high, with a request made during the rerun power-up.
        send_req(1'b1, 8'h70, n);
        push_exp(1'b1, 8'h70, n + 1 + P_SETUP);
        wait_until(n + 1 + P_SETUP);
        chk("en_high_before_reset", {31'b0, bus.lcd_en_o}, 32'd1);
        rst              = 1'b1;
        bus.io_lcd_i[10] = 1'b0;
        @(negedge clk);
        chk_reset_vals("mid_reset");
        r   = cyc;
        rst = 1'b0;
        push_init(r);
        wait_until(r + 4);
        send_req(1'b1, 8'h55, cnt);
        push_exp(1'b1, 8'h55, init_end + 1 + P_SETUP);
        wait_until(init_end - 1);
        chk("reinit_done_before", {31'b0, bus.lcd_init_done_o}, 32'd0);
        @(negedge clk);
        chk("reinit_done_rise", {31'b0, bus.lcd_init_done_o}, 32'd1);
        chk("busy_with_pwrup_request", {31'b0, bus.lcd_busy_o}, 32'd1);
        wait_idle("idle_after_reinit");
        chk("panel_on_after_reset", {31'b0, bus.lcd_on_o}, 32'd1);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
